// File: rtl/symbol_split_if.sv
`default_nettype none
// ============================================================================
// symbol_split_if : block handshake and packed symbol buses for symbol_split
// Revision 1.0
// ============================================================================
interface symbol_split_if #(
   parameter int NSYM = 32,
   parameter int SW   = 10,
   parameter int CW   = 6
);
   logic                 start;
   logic                 in_ready;
   logic [NSYM*SW-1:0]   symbols;
   logic [CW-1:0]        j;
   logic [CW-1:0]        k;
   logic [NSYM*SW-1:0]   fsencoded;
   logic [NSYM*SW-1:0]   kencoded;
   logic [15:0]          enc_bits;
   logic                 out_valid;

   modport master (
      output start, symbols, j, k,
      input  in_ready, fsencoded, kencoded, enc_bits, out_valid
   );

   modport slave (
      input  start, symbols, j, k,
      output in_ready, fsencoded, kencoded, enc_bits, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/symbol_split.sv
`default_nettype none
// ============================================================================
// symbol_split : Rice splitter, one symbol per cycle into (sym>>k, sym&mask)
//                plus the total coded length of the block
// Revision 1.0
// ============================================================================
module symbol_split #(
   parameter int NSYM = 32,
   parameter int SW   = 10,
   parameter int CW   = 6
) (
   input logic           clk,
   input logic           reset_n,
   symbol_split_if.slave bus
);
   localparam int IW = $clog2(NSYM);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SPLIT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              state_q;
   logic                in_ready_q;
   logic                out_valid_q;
   logic [SW-1:0]       sym_q [NSYM];
   logic [SW-1:0]       fs_q  [NSYM];
   logic [SW-1:0]       kd_q  [NSYM];
   logic [CW-1:0]       j_eff_q;
   logic [CW-1:0]       k_eff_q;
   logic [IW-1:0]       idx_q;
   logic [15:0]         acc_q;
   logic [NSYM*SW-1:0]  fsenc_q;
   logic [NSYM*SW-1:0]  kenc_q;
   logic [15:0]         enc_bits_q;

   logic [SW-1:0]       sym_cur_d;
   logic [SW-1:0]       mask_d;
   logic [SW-1:0]       fs_d;
   logic [SW-1:0]       kd_d;
   logic [15:0]         acc_d;
   logic                last_d;
   logic [CW-1:0]       j_clamp_d;
   logic [CW-1:0]       k_clamp_d;

   always_comb begin
      sym_cur_d = sym_q[idx_q];
      // All-ones shifted left by k: k=0 gives mask 0, k=SW gives all ones
      mask_d    = ~({SW{1'b1}} << k_eff_q);
      fs_d      = sym_cur_d >> k_eff_q;
      kd_d      = sym_cur_d & mask_d;
      acc_d     = acc_q + 16'(fs_d) + 16'(k_eff_q) + 16'd1;
      last_d    = (CW'(idx_q) == (j_eff_q - CW'(1)));
      j_clamp_d = (bus.j > CW'(NSYM)) ? CW'(NSYM) : bus.j;
      k_clamp_d = (bus.k > CW'(SW))   ? CW'(SW)   : bus.k;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         j_eff_q     <= '0;
         k_eff_q     <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         fsenc_q     <= '0;
         kenc_q      <= '0;
         enc_bits_q  <= '0;
         for (int i = 0; i < NSYM; i++) begin
            sym_q[i] <= '0;
            fs_q[i]  <= '0;
            kd_q[i]  <= '0;
         end
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start && (bus.j != '0)) begin
                  j_eff_q    <= j_clamp_d;
                  k_eff_q    <= k_clamp_d;
                  idx_q      <= '0;
                  acc_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_SPLIT;
                  for (int i = 0; i < NSYM; i++) begin
                     sym_q[i] <= bus.symbols[NSYM*SW-1-i*SW -: SW];
                     fs_q[i]  <= '0;
                     kd_q[i]  <= '0;
                  end
               end
            end
            S_SPLIT: begin
               fs_q[idx_q] <= fs_d;
               kd_q[idx_q] <= kd_d;
               acc_q       <= acc_d;
               if (last_d) begin
                  state_q <= S_DONE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            S_DONE: begin
               for (int i = 0; i < NSYM; i++) begin
                  fsenc_q[NSYM*SW-1-i*SW -: SW] <= fs_q[i];
                  kenc_q[NSYM*SW-1-i*SW -: SW]  <= kd_q[i];
               end
               enc_bits_q  <= acc_q;
               out_valid_q <= 1'b1;
               in_ready_q  <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.fsencoded = fsenc_q;
   assign bus.kencoded  = kenc_q;
   assign bus.enc_bits  = enc_bits_q;

endmodule
`default_nettype wire
